// File: rtl/power_spectrum_packetizer.sv
// Serialises one sweep of wide power words into a byte AXI-Stream frame: 16-bit sequence
// header, then payload bytes MSB-first. Define PEAK_TRAILER_EN to append a peak-index trailer.
module power_spectrum_packetizer #(
  parameter int unsigned DATA_WIDTH = 88,
  parameter int unsigned MAX_BINS   = 181,
  parameter int unsigned IDX_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  overflow
);

  localparam int unsigned Bytes    = DATA_WIDTH / 8;
  localparam int unsigned CntWidth = $clog2(Bytes) + 1;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StPayload,
    StWait,
    StEnd,
`ifdef PEAK_TRAILER_EN
    StTrailer,
`endif
    StDiscard
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  last_q, last_d;
  logic                  trunc_q, trunc_d;
  logic [IDX_WIDTH-1:0]  bin_q, bin_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [15:0]           seq_q, seq_d;
  logic [7:0]            m_tdata_q, m_tdata_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic                  m_tlast_q, m_tlast_d;
  logic                  overflow_q, overflow_d;
`ifdef PEAK_TRAILER_EN
  logic [DATA_WIDTH-1:0] peak_val_q, peak_val_d;
  logic [IDX_WIDTH-1:0]  peak_idx_q, peak_idx_d;
  logic [15:0]           trailer_word;
  assign trailer_word = 16'(peak_idx_q);
`endif

  logic                 accept;
  logic                 out_free;
  logic [IDX_WIDTH-1:0] accept_bin;
  logic                 at_limit;

  assign s_axis_tready = (state_q == StIdle) || (state_q == StWait) || (state_q == StDiscard);
  assign accept        = s_axis_tvalid && s_axis_tready;
  // Output register may be reloaded when empty or being drained this cycle.
  assign out_free      = !m_tvalid_q || m_axis_tready;
  assign accept_bin    = (state_q == StIdle) ? '0 : bin_q + 1'b1;
  assign at_limit      = (accept_bin == IDX_WIDTH'(MAX_BINS - 1));

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign overflow      = overflow_q;

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    last_d     = last_q;
    trunc_d    = trunc_q;
    bin_d      = bin_q;
    cnt_d      = cnt_q;
    seq_d      = seq_q;
    m_tdata_d  = m_tdata_q;
    m_tvalid_d = m_tvalid_q;
    m_tlast_d  = m_tlast_q;
    overflow_d = 1'b0;
`ifdef PEAK_TRAILER_EN
    peak_val_d = peak_val_q;
    peak_idx_d = peak_idx_q;
`endif
    if (m_tvalid_q && m_axis_tready) begin
      m_tvalid_d = 1'b0;
      m_tlast_d  = 1'b0;
    end

    case (state_q)
      StIdle, StWait: begin
        if (accept) begin
          word_d     = s_axis_tdata;
          last_d     = s_axis_tlast || at_limit;
          trunc_d    = !s_axis_tlast && at_limit;
          overflow_d = !s_axis_tlast && at_limit;
          bin_d      = accept_bin;
`ifdef PEAK_TRAILER_EN
          // Strictly greater: the first occurrence of the maximum wins.
          if ((state_q == StIdle) || (s_axis_tdata > peak_val_q)) begin
            peak_val_d = s_axis_tdata;
            peak_idx_d = accept_bin;
          end
`endif
          if (state_q == StIdle) begin
            cnt_d   = '0;
            state_d = StHdr;
          end else begin
            cnt_d   = CntWidth'(Bytes - 1);
            state_d = StPayload;
          end
        end
      end
      StHdr: begin
        if (out_free) begin
          m_tvalid_d = 1'b1;
          m_tlast_d  = 1'b0;
          if (cnt_q == '0) begin
            m_tdata_d = seq_q[15:8];
            cnt_d     = 1;
          end else begin
            m_tdata_d = seq_q[7:0];
            cnt_d     = CntWidth'(Bytes - 1);
            state_d   = StPayload;
          end
        end
      end
      StPayload: begin
        if (out_free) begin
          m_tvalid_d = 1'b1;
          m_tlast_d  = 1'b0;
          m_tdata_d  = word_q[8*cnt_q +: 8];
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (!last_q) begin
            state_d = StWait;
          end else begin
`ifdef PEAK_TRAILER_EN
            state_d = StTrailer;
`else
            m_tlast_d = 1'b1;
            state_d   = StEnd;
`endif
          end
        end
      end
`ifdef PEAK_TRAILER_EN
      StTrailer: begin
        if (out_free) begin
          m_tvalid_d = 1'b1;
          if (cnt_q == '0) begin
            m_tdata_d = trailer_word[15:8];
            m_tlast_d = 1'b0;
            cnt_d     = 1;
          end else begin
            m_tdata_d = trailer_word[7:0];
            m_tlast_d = 1'b1;
            state_d   = StEnd;
          end
        end
      end
`endif
      StEnd: begin
        // Only the tlast byte can be in the output register here.
        if (m_tvalid_q && m_axis_tready) begin
          seq_d   = seq_q + 16'd1;
          state_d = trunc_q ? StDiscard : StIdle;
        end
      end
      StDiscard: begin
        if (accept && s_axis_tlast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      word_q     <= '0;
      last_q     <= 1'b0;
      trunc_q    <= 1'b0;
      bin_q      <= '0;
      cnt_q      <= '0;
      seq_q      <= '0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      overflow_q <= 1'b0;
`ifdef PEAK_TRAILER_EN
      peak_val_q <= '0;
      peak_idx_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      last_q     <= last_d;
      trunc_q    <= trunc_d;
      bin_q      <= bin_d;
      cnt_q      <= cnt_d;
      seq_q      <= seq_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
      overflow_q <= overflow_d;
`ifdef PEAK_TRAILER_EN
      peak_val_q <= peak_val_d;
      peak_idx_q <= peak_idx_d;
`endif
    end
  end

endmodule
